// File: rtl/cpu_decode_pkg.sv
// Shared decode-stage definitions: PCB layout, form 2/3 control word and FSM states.
package cpu_decode_pkg;

  localparam int unsigned PCB_WIDTH   = 32;
  localparam int unsigned PCB_IMM_BIT = 0;

  localparam logic [PCB_WIDTH-1:0] PCB_FORM23 = '1;

  typedef enum logic [1:0] {
    S_OP     = 2'd0,
    S_IMM_HI = 2'd1,
    S_IMM_LO = 2'd2
  } dec_state_e;

endpackage

// File: rtl/microcode.sv
// Microcode ROM: maps the opcode byte to its pipeline control block word.
module microcode
  import cpu_decode_pkg::*;
(
  input  logic [7:0]           addr,
  output logic [PCB_WIDTH-1:0] pcb
);

  // PCB bits: [0] imm32, [1] reg write, [2] mem read, [3] mem write, [4] branch, [7:5] alu op
  always_comb begin
    pcb = '0;
    if (addr[7]) begin
      pcb = PCB_FORM23;
    end else begin
      case (addr[6:0])
        7'h01:   pcb = 32'h0000_0003;
        7'h02:   pcb = 32'h0000_0002;
        7'h03:   pcb = 32'h0000_0011;
        7'h05:   pcb = 32'h0000_0022;
        7'h06:   pcb = 32'h0000_0008;
        7'h07:   pcb = 32'h0000_0006;
        7'h08:   pcb = 32'h0000_0007;
        7'h09:   pcb = 32'h0000_0009;
        7'h0A:   pcb = 32'h0000_0006;
        7'h0B:   pcb = 32'h0000_0008;
        7'h0E:   pcb = 32'h0000_0040;
        7'h29:   pcb = 32'h0000_0062;
        default: pcb = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_decode.sv
// Decode stage: assembles opcode + optional 32-bit immediate halfwords into one
// registered instruction per handshake, with PCB lookup, stall and flush.
module cpu_decode
  import cpu_decode_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fetch_valid_i,
  input  logic [15:0]           fetch_half_i,
  input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
  output logic                  fetch_ready_o,
  output logic                  dx_valid_o,
  input  logic                  dx_ready_i,
  output logic [15:0]           dx_insn_o,
  output logic [31:0]           dx_imm_o,
  output logic [PCB_WIDTH-1:0]  dx_pcb_o,
  output logic [ADDR_WIDTH-1:0] dx_pc_o,
  output logic [3:0]            dx_reg_a_o,
  output logic [3:0]            dx_reg_b_o,
  output logic                  dx_long_o
);

  dec_state_e            state;
  logic [PCB_WIDTH-1:0]  rom_pcb;
  logic                  is_long;
  logic                  accept;
  logic [15:0]           insn_hold;
  logic [15:0]           imm_hi_hold;
  logic [ADDR_WIDTH-1:0] pc_hold;
  logic [PCB_WIDTH-1:0]  pcb_hold;

  microcode u_microcode (
    .addr (fetch_half_i[15:8]),
    .pcb  (rom_pcb)
  );

  // Form 2/3 words are all-ones, so the imm bit must be masked by opcode bit 15.
  always_comb begin
    is_long       = ~fetch_half_i[15] & rom_pcb[PCB_IMM_BIT];
    fetch_ready_o = ~rst_i & ~flush_i & (~dx_valid_o | dx_ready_i);
    accept        = fetch_valid_i & fetch_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_OP;
      insn_hold   <= '0;
      imm_hi_hold <= '0;
      pc_hold     <= '0;
      pcb_hold    <= '0;
      dx_valid_o  <= 1'b0;
      dx_insn_o   <= '0;
      dx_imm_o    <= '0;
      dx_pcb_o    <= '0;
      dx_pc_o     <= '0;
      dx_reg_a_o  <= '0;
      dx_reg_b_o  <= '0;
      dx_long_o   <= 1'b0;
    end else if (flush_i) begin
      state       <= S_OP;
      insn_hold   <= '0;
      imm_hi_hold <= '0;
      pc_hold     <= '0;
      pcb_hold    <= '0;
      dx_valid_o  <= 1'b0;
    end else begin
      // A load later in this block overrides the consume-clear.
      if (dx_valid_o && dx_ready_i)
        dx_valid_o <= 1'b0;
      if (accept) begin
        case (state)
          S_OP: begin
            insn_hold <= fetch_half_i;
            pc_hold   <= fetch_pc_i;
            pcb_hold  <= rom_pcb;
            if (is_long) begin
              state <= S_IMM_HI;
            end else begin
              dx_valid_o <= 1'b1;
              dx_insn_o  <= fetch_half_i;
              dx_reg_a_o <= fetch_half_i[7:4];
              dx_reg_b_o <= fetch_half_i[3:0];
              dx_pc_o    <= fetch_pc_i;
              dx_pcb_o   <= rom_pcb;
              dx_imm_o   <= '0;
              dx_long_o  <= 1'b0;
            end
          end
          S_IMM_HI: begin
            imm_hi_hold <= fetch_half_i;
            state       <= S_IMM_LO;
          end
          S_IMM_LO: begin
            dx_valid_o <= 1'b1;
            dx_insn_o  <= insn_hold;
            dx_reg_a_o <= insn_hold[7:4];
            dx_reg_b_o <= insn_hold[3:0];
            dx_pc_o    <= pc_hold;
            dx_pcb_o   <= pcb_hold;
            dx_imm_o   <= {imm_hi_hold, fetch_half_i};
            dx_long_o  <= 1'b1;
            state      <= S_OP;
          end
          default: state <= S_OP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_decode.sv
// Bench for cpu_decode: directed plan steps then random traffic, checked against
// an instruction-level reference model (halfword queue, not FSM states).
module tb_cpu_decode;
  import cpu_decode_pkg::*;

  localparam int unsigned AW = 32;

  logic                 clk = 1'b0;
  logic                 rst, flush, fv, rdy;
  logic [15:0]          half;
  logic [AW-1:0]        pc;
  logic                 fetch_ready_o, dx_valid_o, dx_long_o;
  logic [15:0]          dx_insn_o;
  logic [31:0]          dx_imm_o;
  logic [PCB_WIDTH-1:0] dx_pcb_o;
  logic [AW-1:0]        dx_pc_o;
  logic [3:0]           dx_reg_a_o, dx_reg_b_o;

  int total = 0;
  int bad   = 0;

  logic                 m_valid = 1'b0;
  logic [15:0]          m_insn  = '0;
  logic [31:0]          m_imm   = '0;
  logic [PCB_WIDTH-1:0] m_pcb   = '0;
  logic [AW-1:0]        m_pc    = '0;
  logic                 m_long  = 1'b0;
  logic [15:0]          pq[$];
  logic [AW-1:0]        p_pc;
  logic [PCB_WIDTH-1:0] p_pcb;

  logic [7:0] ops [13] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0E, 8'h29};

  cpu_decode #(.ADDR_WIDTH(AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .fetch_valid_i (fv),
    .fetch_half_i  (half),
    .fetch_pc_i    (pc),
    .fetch_ready_o (fetch_ready_o),
    .dx_valid_o    (dx_valid_o),
    .dx_ready_i    (rdy),
    .dx_insn_o     (dx_insn_o),
    .dx_imm_o      (dx_imm_o),
    .dx_pcb_o      (dx_pcb_o),
    .dx_pc_o       (dx_pc_o),
    .dx_reg_a_o    (dx_reg_a_o),
    .dx_reg_b_o    (dx_reg_b_o),
    .dx_long_o     (dx_long_o)
  );

  always #5 clk = ~clk;

  // Reference control words per opcode byte (ISA table).
  function automatic logic [PCB_WIDTH-1:0] pcb_ref(input logic [7:0] op);
    if (op >= 8'h80) return '1;
    case (op)
      8'h01: return 32'h03;
      8'h02: return 32'h02;
      8'h03: return 32'h11;
      8'h05: return 32'h22;
      8'h06: return 32'h08;
      8'h07: return 32'h06;
      8'h08: return 32'h07;
      8'h09: return 32'h09;
      8'h0A: return 32'h06;
      8'h0B: return 32'h08;
      8'h0E: return 32'h40;
      8'h29: return 32'h62;
      default: return '0;
    endcase
  endfunction

  function automatic bit has_imm(input logic [7:0] op);
    return (op == 8'h01) || (op == 8'h03) || (op == 8'h08) || (op == 8'h09);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic v,
                      input logic [15:0] h, input logic [AW-1:0] a, input logic rd);
    logic exp_rdy;
    rst = r; flush = f; fv = v; half = h; pc = a; rdy = rd;
    #1;
    exp_rdy = !r && !f && (!m_valid || rd);
    chk("fetch_ready", {63'd0, fetch_ready_o}, {63'd0, exp_rdy});
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_insn = '0; m_imm = '0; m_pcb = '0; m_pc = '0; m_long = 0;
      pq.delete();
    end else if (f) begin
      m_valid = 0;
      pq.delete();
    end else begin
      if (m_valid && rd) m_valid = 0;
      if (v && exp_rdy) begin
        if (pq.size() == 0) begin
          if (!has_imm(h[15:8])) begin
            m_valid = 1; m_insn = h; m_imm = '0; m_pcb = pcb_ref(h[15:8]);
            m_pc = a; m_long = 0;
          end else begin
            pq.push_back(h); p_pc = a; p_pcb = pcb_ref(h[15:8]);
          end
        end else if (pq.size() == 1) begin
          pq.push_back(h);
        end else begin
          m_valid = 1; m_insn = pq[0]; m_imm = {pq[1], h}; m_pcb = p_pcb;
          m_pc = p_pc; m_long = 1;
          pq.delete();
        end
      end
    end
    #1;
    chk("dx_valid", {63'd0, dx_valid_o}, {63'd0, m_valid});
    chk("dx_insn",  {48'd0, dx_insn_o},  {48'd0, m_insn});
    chk("dx_imm",   {32'd0, dx_imm_o},   {32'd0, m_imm});
    chk("dx_pcb",   {32'd0, dx_pcb_o},   {32'd0, m_pcb});
    chk("dx_pc",    {32'd0, dx_pc_o},    {32'd0, m_pc});
    chk("dx_reg_a", {60'd0, dx_reg_a_o}, {60'd0, m_insn[7:4]});
    chk("dx_reg_b", {60'd0, dx_reg_b_o}, {60'd0, m_insn[3:0]});
    chk("dx_long",  {63'd0, dx_long_o},  {63'd0, m_long});
  endtask

  initial begin
    logic [15:0] h;
    logic [7:0]  op;
    int unsigned sel;

    // Reset with fetch presenting data
    for (int i = 0; i < 3; i++) step(1, 0, 1, 16'h0512, 32'h0, 1);
    chk("rst_valid", {63'd0, dx_valid_o}, 64'd0);

    // Short back-to-back stream
    step(0, 0, 1, 16'h0512, 32'h1000, 1);
    chk("t2_insn0", {48'd0, dx_insn_o}, 64'h0512);
    chk("t2_rega0", {60'd0, dx_reg_a_o}, 64'd1);
    chk("t2_regb0", {60'd0, dx_reg_b_o}, 64'd2);
    step(0, 0, 1, 16'h0534, 32'h1002, 1);
    chk("t2_insn1", {48'd0, dx_insn_o}, 64'h0534);
    chk("t2_valid1", {63'd0, dx_valid_o}, 64'd1);
    chk("t2_pc1", {32'd0, dx_pc_o}, 64'h1002);
    step(0, 0, 0, 16'h0, 32'h0, 1);

    // Long ldi.l
    step(0, 0, 1, 16'h0110, 32'h2000, 1);
    step(0, 0, 1, 16'hDEAD, 32'h2002, 1);
    chk("t3_novalid", {63'd0, dx_valid_o}, 64'd0);
    step(0, 0, 1, 16'hBEEF, 32'h2004, 1);
    chk("t3_imm", {32'd0, dx_imm_o}, 64'hDEADBEEF);
    chk("t3_pc", {32'd0, dx_pc_o}, 64'h2000);
    chk("t3_long", {63'd0, dx_long_o}, 64'd1);
    step(0, 0, 0, 16'h0, 32'h0, 1);
    chk("t3_pulse", {63'd0, dx_valid_o}, 64'd0);

    // Stall then release with same-cycle accept
    step(0, 0, 1, 16'h0512, 32'h3000, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0534, 32'h3002, 0);
    chk("t4_held", {48'd0, dx_insn_o}, 64'h0512);
    step(0, 0, 1, 16'h0534, 32'h3002, 1);
    chk("t4_next", {48'd0, dx_insn_o}, 64'h0534);
    chk("t4_valid", {63'd0, dx_valid_o}, 64'd1);
    step(0, 0, 0, 16'h0, 32'h0, 1);

    // Flush mid-long
    step(0, 0, 1, 16'h0110, 32'h4000, 1);
    step(0, 0, 1, 16'h1234, 32'h4002, 1);
    step(0, 1, 1, 16'h5678, 32'h4004, 1);
    chk("t5_flush", {63'd0, dx_valid_o}, 64'd0);
    step(0, 0, 1, 16'h0512, 32'h4008, 1);
    chk("t5_short", {63'd0, dx_long_o}, 64'd0);
    chk("t5_insn", {48'd0, dx_insn_o}, 64'h0512);
    step(0, 0, 0, 16'h0, 32'h0, 1);

    // Form 2/3
    step(0, 0, 1, 16'h8A55, 32'h5000, 1);
    chk("t6_pcb", {32'd0, dx_pcb_o}, 64'hFFFF_FFFF);
    chk("t6_long", {63'd0, dx_long_o}, 64'd0);
    chk("t6_imm", {32'd0, dx_imm_o}, 64'd0);
    step(0, 0, 1, 16'h0110, 32'h5002, 1);
    chk("t6_newop", {63'd0, dx_valid_o}, 64'd0);
    step(0, 0, 1, 16'hCAFE, 32'h5004, 1);
    step(0, 0, 1, 16'hF00D, 32'h5006, 1);
    chk("t6_imm2", {32'd0, dx_imm_o}, 64'hCAFEF00D);
    chk("t6_pc2", {32'd0, dx_pc_o}, 64'h5002);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (pq.size() != 0) begin
        h = 16'($urandom);
      end else begin
        sel = $urandom % 8;
        if (sel < 5)       op = ops[$urandom % 13];
        else if (sel == 5) op = 8'h80 | 8'($urandom);
        else if (sel == 6) op = 8'($urandom % 128);
        else               op = 8'h01;
        h = {op, 8'($urandom)};
      end
      step(($urandom % 100) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
           h, $urandom, ($urandom % 10) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
